// File: rtl/rc522_init_seq.sv
// rc522_init_seq
//   Power-up sequencer for the MFRC522 reader and the only master of the
//   rc522_if user API. A start pulse runs: soft reset, wait, poll CommandReg
//   until PowerDown clears, a fixed register table, an antenna-on
//   read-modify-write of TxControlReg, then a VersionReg check. The result
//   is reported with a one-cycle done pulse plus ok/err/version levels.
// Ports
//   clk, rst_n       clock, async active-low reset
//   start            1-cycle run request (ignored while busy or on done cycle)
//   busy, done       run in progress / end-of-run pulse
//   ok, err          pass level; error code 00 none, 01 poll timeout, 10 version
//   version          VersionReg value of the last run
//   if_req_write/_read, if_addr, if_wr_data   request side of rc522_if
//   if_rd_data, if_data_valid, if_busy        response side of rc522_if
module rc522_init_seq #(
  parameter int RST_WAIT_CYCLES = 50000,
  parameter int POLL_LIMIT      = 16,
  parameter int POLL_GAP_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ok,
  output logic [1:0] err,
  output logic [7:0] version,
  output logic       if_req_write,
  output logic       if_req_read,
  output logic [7:0] if_addr,
  output logic [7:0] if_wr_data,
  input  logic [7:0] if_rd_data,
  input  logic       if_data_valid,
  input  logic       if_busy
);
  localparam int RCW = $clog2(RST_WAIT_CYCLES + 1);
  localparam int PCW = $clog2(POLL_LIMIT + 1);
  localparam int GCW = $clog2(POLL_GAP_CYCLES + 1);
  localparam logic [RCW-1:0] RST_LAST  = RCW'(RST_WAIT_CYCLES - 1);
  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_LIMIT - 1);
  localparam logic [GCW-1:0] GAP_LAST  = GCW'(POLL_GAP_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RST_WR, S_RST_WAIT, S_POLL_RD, S_POLL_GAP,
    S_TBL_WR, S_ANT_RD, S_ANT_WR, S_VER_RD, S_FINISH
  } state_t;

  state_t         state_q;
  logic           phase_q;   // 0 = issue, 1 = wait for data_valid
  logic           busy_q, done_q, ok_q;
  logic [1:0]     err_q;
  logic [7:0]     version_q, ant_q;
  logic           req_wr_q, req_rd_q;
  logic [7:0]     addr_q, wdata_q;
  logic [RCW-1:0] rst_cnt_q;
  logic [PCW-1:0] poll_cnt_q;
  logic [GCW-1:0] gap_cnt_q;
  logic [2:0]     tbl_idx_q;

  // Register init table: {address, data}
  function automatic logic [15:0] tbl_entry(input logic [2:0] idx);
    case (idx)
      3'd0:    tbl_entry = 16'h2A_8D;  // TModeReg
      3'd1:    tbl_entry = 16'h2B_3E;  // TPrescalerReg
      3'd2:    tbl_entry = 16'h2D_1E;  // TReloadReg low
      3'd3:    tbl_entry = 16'h2C_00;  // TReloadReg high
      3'd4:    tbl_entry = 16'h15_40;  // TxASKReg
      3'd5:    tbl_entry = 16'h11_3D;  // ModeReg
      default: tbl_entry = 16'h00_00;
    endcase
  endfunction

  // Access descriptor of the current state; acc_en=0 for non-access states.
  logic       acc_en, acc_wr;
  logic [7:0] acc_addr, acc_data;
  always_comb begin
    acc_en   = 1'b1;
    acc_wr   = 1'b0;
    acc_addr = 8'h00;
    acc_data = 8'h00;
    case (state_q)
      S_RST_WR:  begin acc_wr = 1'b1; acc_addr = 8'h01; acc_data = 8'h0F; end
      S_POLL_RD: acc_addr = 8'h01;
      S_TBL_WR:  begin acc_wr = 1'b1; {acc_addr, acc_data} = tbl_entry(tbl_idx_q); end
      S_ANT_RD:  acc_addr = 8'h14;
      S_ANT_WR:  begin acc_wr = 1'b1; acc_addr = 8'h14; acc_data = ant_q | 8'h03; end
      S_VER_RD:  acc_addr = 8'h37;
      default:   acc_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ok_q       <= 1'b0;
      err_q      <= 2'b00;
      version_q  <= 8'h00;
      ant_q      <= 8'h00;
      req_wr_q   <= 1'b0;
      req_rd_q   <= 1'b0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      rst_cnt_q  <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      tbl_idx_q  <= '0;
    end else begin
      req_wr_q <= 1'b0;
      req_rd_q <= 1'b0;
      done_q   <= 1'b0;
      if (acc_en) begin
        if (!phase_q) begin
          // addr/data are registered with the req and held until data_valid
          if (!if_busy) begin
            req_wr_q <= acc_wr;
            req_rd_q <= !acc_wr;
            addr_q   <= acc_addr;
            wdata_q  <= acc_data;
            phase_q  <= 1'b1;
          end
        end else if (if_data_valid) begin
          phase_q <= 1'b0;
          case (state_q)
            S_RST_WR: begin
              rst_cnt_q <= '0;
              state_q   <= S_RST_WAIT;
            end
            S_POLL_RD: begin
              if (if_rd_data[4]) begin
                poll_cnt_q <= poll_cnt_q + PCW'(1);
                if (poll_cnt_q == POLL_LAST) begin
                  err_q   <= 2'b01;
                  state_q <= S_FINISH;
                end else begin
                  gap_cnt_q <= '0;
                  state_q   <= S_POLL_GAP;
                end
              end else begin
                tbl_idx_q <= '0;
                state_q   <= S_TBL_WR;
              end
            end
            S_TBL_WR: begin
              if (tbl_idx_q == 3'd5) state_q <= S_ANT_RD;
              else                   tbl_idx_q <= tbl_idx_q + 3'd1;
            end
            S_ANT_RD: begin
              ant_q   <= if_rd_data;
              state_q <= S_ANT_WR;
            end
            S_ANT_WR: state_q <= S_VER_RD;
            S_VER_RD: begin
              version_q <= if_rd_data;
              if (if_rd_data != 8'h91 && if_rd_data != 8'h92) err_q <= 2'b10;
              state_q <= S_FINISH;
            end
            default: state_q <= S_IDLE;
          endcase
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            // done_q high means this is the done cycle: a start here is dropped
            if (start && !done_q) begin
              err_q      <= 2'b00;
              ok_q       <= 1'b0;
              version_q  <= 8'h00;
              poll_cnt_q <= '0;
              busy_q     <= 1'b1;
              phase_q    <= 1'b0;
              state_q    <= S_RST_WR;
            end
          end
          S_RST_WAIT: begin
            if (rst_cnt_q == RST_LAST) state_q <= S_POLL_RD;
            else                       rst_cnt_q <= rst_cnt_q + RCW'(1);
          end
          S_POLL_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_q <= S_POLL_RD;
            else                       gap_cnt_q <= gap_cnt_q + GCW'(1);
          end
          S_FINISH: begin
            done_q  <= 1'b1;
            ok_q    <= (err_q == 2'b00);
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign ok           = ok_q;
  assign err          = err_q;
  assign version      = version_q;
  assign if_req_write = req_wr_q;
  assign if_req_read  = req_rd_q;
  assign if_addr      = addr_q;
  assign if_wr_data   = wdata_q;
endmodule

// File: tb/tb_rc522_init_seq.sv
// Directed bench for rc522_init_seq with a small rc522_if responder model.
module tb_rc522_init_seq;
  localparam int RW = 20;
  localparam int PL = 4;
  localparam int PG = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, ok;
  logic [1:0] err;
  logic [7:0] version;
  logic       if_req_write, if_req_read;
  logic [7:0] if_addr, if_wr_data;
  logic [7:0] if_rd_data;
  logic       if_data_valid;
  logic       if_busy;

  rc522_init_seq #(.RST_WAIT_CYCLES(RW), .POLL_LIMIT(PL), .POLL_GAP_CYCLES(PG)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .busy(busy), .done(done), .ok(ok), .err(err), .version(version),
    .if_req_write(if_req_write), .if_req_read(if_req_read),
    .if_addr(if_addr), .if_wr_data(if_wr_data),
    .if_rd_data(if_rd_data), .if_data_valid(if_data_valid), .if_busy(if_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // responder model state
  int          poll_ones;
  int          poll_idx;
  logic [7:0]  tx_val, ver_val;
  logic [16:0] log_q[$];   // {is_write, addr, data(0 for reads)}
  int          log_t[$];
  logic [16:0] exp_q[$];
  bit          stab_bad, ovl_bad;
  int          r_cnt;
  bit          r_pend;
  logic [7:0]  r_addr, r_data;
  logic        r_wr;

  function automatic logic [7:0] model_rd(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    if (a == 8'h01) begin
      v = (poll_idx < poll_ones) ? 8'h30 : 8'h20;
      poll_idx++;
    end else if (a == 8'h14) v = tx_val;
    else if (a == 8'h37)     v = ver_val;
    return v;
  endfunction

  // rc522_if stand-in: 3-cycle access latency, busy while outstanding
  initial begin
    if_busy = 1'b0; if_data_valid = 1'b0; if_rd_data = 8'h00;
    r_pend = 1'b0; r_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        r_pend = 1'b0; if_busy = 1'b0; if_data_valid = 1'b0;
      end else begin
        if (r_pend && (if_addr !== r_addr || (r_wr && if_wr_data !== r_data))) stab_bad = 1'b1;
        if (if_data_valid) begin if_data_valid = 1'b0; if_busy = 1'b0; end
        if (r_pend) begin
          r_cnt--;
          if (r_cnt == 0) begin
            r_pend = 1'b0;
            if_data_valid = 1'b1;
            if_rd_data = r_wr ? 8'h00 : model_rd(r_addr);
          end
        end
        if (if_req_write || if_req_read) begin
          if (if_req_write && if_req_read) ovl_bad = 1'b1;
          if (r_pend || if_busy) ovl_bad = 1'b1;
          r_addr = if_addr; r_data = if_wr_data; r_wr = if_req_write;
          r_pend = 1'b1; r_cnt = 3; if_busy = 1'b1;
          log_q.push_back({r_wr, r_addr, r_wr ? r_data : 8'h00});
          log_t.push_back(cyc);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int ones, input logic [7:0] tx, input logic [7:0] ver);
    poll_ones = ones; poll_idx = 0; tx_val = tx; ver_val = ver;
    log_q.delete(); log_t.delete(); exp_q.delete();
    stab_bad = 1'b0; ovl_bad = 1'b0;
  endtask

  task automatic build_exp(input int npolls, input bit timeout, input logic [7:0] tx);
    exp_q.push_back({1'b1, 8'h01, 8'h0F});
    for (int i = 0; i < npolls; i++) exp_q.push_back({1'b0, 8'h01, 8'h00});
    if (!timeout) begin
      exp_q.push_back({1'b1, 8'h2A, 8'h8D});
      exp_q.push_back({1'b1, 8'h2B, 8'h3E});
      exp_q.push_back({1'b1, 8'h2D, 8'h1E});
      exp_q.push_back({1'b1, 8'h2C, 8'h00});
      exp_q.push_back({1'b1, 8'h15, 8'h40});
      exp_q.push_back({1'b1, 8'h11, 8'h3D});
      exp_q.push_back({1'b0, 8'h14, 8'h00});
      exp_q.push_back({1'b1, 8'h14, tx | 8'h03});
      exp_q.push_back({1'b0, 8'h37, 8'h00});
    end
  endtask

  task automatic check_log(input string name);
    int n;
    chk({name, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_acc%0d", name, i), log_q[i], exp_q[i]);
    chk({name, "_stable"}, stab_bad, 1'b0);
    chk({name, "_one_req"}, ovl_bad, 1'b0);
  endtask

  task automatic pulse_start(input string name);
    @(posedge clk); #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    chk({name, "_busy_after_start"}, busy, 1'b1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin @(posedge clk); #2; n++; end
    chk({name, "_done_seen"}, done, 1'b1);
    chk({name, "_busy_on_done"}, busy, 1'b0);
  endtask

  initial begin
    setup(0, 8'h00, 8'h00);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outputs", {busy, done, ok, err, version, if_req_write, if_req_read, if_addr, if_wr_data},
        32'h0);
    rst_n = 1'b1;

    // T1: PowerDown clear on first poll, VersionReg 92
    setup(0, 8'h10, 8'h92);
    build_exp(1, 1'b0, 8'h10);
    pulse_start("t1");
    chk("t1_err_cleared", err, 2'b00);
    wait_done("t1", 3000);
    chk("t1_ok", ok, 1'b1);
    chk("t1_err", err, 2'b00);
    chk("t1_version", version, 8'h92);
    check_log("t1");
    if (log_t.size() >= 2) chk("t1_rst_wait", (log_t[1] - log_t[0] >= RW) ? 1 : 0, 1);
    @(posedge clk); #2;
    chk("t1_done_one_cycle", done, 1'b0);

    // T2: PowerDown set for 3 polls, then clear
    setup(3, 8'h00, 8'h91);
    build_exp(4, 1'b0, 8'h00);
    pulse_start("t2");
    chk("t2_ok_cleared", ok, 1'b0);
    wait_done("t2", 3000);
    chk("t2_ok", ok, 1'b1);
    chk("t2_err", err, 2'b00);
    chk("t2_version", version, 8'h91);
    check_log("t2");
    for (int i = 1; i < 4; i++)
      if (log_t.size() > i + 1) chk($sformatf("t2_gap%0d", i), (log_t[i+1] - log_t[i] >= PG) ? 1 : 0, 1);

    // T3: PowerDown stuck -> timeout after exactly POLL_LIMIT reads
    setup(1000, 8'h00, 8'h92);
    build_exp(PL, 1'b1, 8'h00);
    pulse_start("t3");
    chk("t3_version_cleared", version, 8'h00);
    wait_done("t3", 3000);
    chk("t3_ok", ok, 1'b0);
    chk("t3_err", err, 2'b01);
    chk("t3_version", version, 8'h00);
    check_log("t3");

    // T4: TxControl 80 -> write 83; bad version 12
    setup(0, 8'h80, 8'h12);
    build_exp(1, 1'b0, 8'h80);
    pulse_start("t4");
    chk("t4_err_cleared", err, 2'b00);
    wait_done("t4", 3000);
    chk("t4_ok", ok, 1'b0);
    chk("t4_err", err, 2'b10);
    chk("t4_version", version, 8'h12);
    check_log("t4");

    // T5a: start while busy and on the done cycle are ignored
    setup(0, 8'h01, 8'h92);
    build_exp(1, 1'b0, 8'h01);
    pulse_start("t5");
    repeat (5) @(posedge clk);
    #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    repeat (30) @(posedge clk);
    #2; start = 1'b1;
    @(posedge clk); #2; start = 1'b0;
    wait_done("t5", 3000);
    start = 1'b1;                       // coincident with the done cycle
    @(posedge clk); #2; start = 1'b0;
    chk("t5_start_on_done_busy", busy, 1'b0);
    repeat (20) @(posedge clk);
    #2;
    chk("t5_ok", ok, 1'b1);
    check_log("t5");

    // T5b: reset in the middle of the table
    setup(0, 8'h00, 8'h92);
    pulse_start("t5r");
    begin
      int n;
      n = 0;
      while (log_q.size() < 4 && n < 3000) begin @(posedge clk); #2; n++; end
      chk("t5r_reached_table", (log_q.size() >= 4) ? 1 : 0, 1);
    end
    rst_n = 1'b0;
    #1;
    chk("t5r_outputs_reset", {busy, done, ok, err, version, if_req_write, if_req_read, if_addr, if_wr_data},
        32'h0);
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b1;
    begin
      int n0;
      n0 = log_q.size();
      repeat (40) @(posedge clk);
      #2;
      chk("t5r_no_req_after_reset", log_q.size(), n0);
      chk("t5r_idle_busy", busy, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
